// File: rtl/aludec_md_pkg.sv
// Shared codes for the ALU control decoder and its multiply/divide unit:
// ALU control values, function fields, MD state encodings and HI/LO read selects.
package aludec_pkg;

   localparam logic [3:0] ALUCTRL_AND  = 4'b0000;
   localparam logic [3:0] ALUCTRL_OR   = 4'b0001;
   localparam logic [3:0] ALUCTRL_ADD  = 4'b0010;
   localparam logic [3:0] ALUCTRL_XOR  = 4'b0011;
   localparam logic [3:0] ALUCTRL_NOR  = 4'b0100;
   localparam logic [3:0] ALUCTRL_SUB  = 4'b0110;
   localparam logic [3:0] ALUCTRL_SLT  = 4'b0111;
   localparam logic [3:0] ALUCTRL_SLTU = 4'b1111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_SLT   = 2'b11;

   localparam logic [5:0] FUNCT_ADD   = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
   localparam logic [5:0] FUNCT_SUB   = 6'b100010;
   localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
   localparam logic [5:0] FUNCT_AND   = 6'b100100;
   localparam logic [5:0] FUNCT_OR    = 6'b100101;
   localparam logic [5:0] FUNCT_XOR   = 6'b100110;
   localparam logic [5:0] FUNCT_NOR   = 6'b100111;
   localparam logic [5:0] FUNCT_SLT   = 6'b101010;
   localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MUL  = 2'd1,
      MD_DIV  = 2'd2,
      MD_FIX  = 2'd3
   } md_state_e;

   localparam logic [1:0] MF_NONE = 2'b00;
   localparam logic [1:0] MF_HI   = 2'b01;
   localparam logic [1:0] MF_LO   = 2'b10;

   // Functs that read, write or compute HI/LO (0100xx moves, 0110xx mult/div).
   function automatic logic is_hilo_funct(input logic [5:0] f);
      return (f[5:2] == 4'b0100) || (f[5:2] == 4'b0110);
   endfunction

endpackage

// File: rtl/aludec_md_if.sv
// Decode-stage bus of the ALU decoder: instruction fields and operands in,
// ALU control, HI/LO state and hazard signals out.
interface aludec_md_if #(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
);
   logic [1:0]        aluop;
   logic [5:0]        funct;
   logic              issue;
   logic [WIDTH-1:0]  srca;
   logic [WIDTH-1:0]  srcb;
   logic [CTRL_W-1:0] alucontrol;
   logic              illegal;
   logic [1:0]        mf_sel;
   logic [WIDTH-1:0]  hi;
   logic [WIDTH-1:0]  lo;
   logic              busy;
   logic              stall;

   modport master (
      output aluop, funct, issue, srca, srcb,
      input  alucontrol, illegal, mf_sel, hi, lo, busy, stall
   );

   modport slave (
      input  aluop, funct, issue, srca, srcb,
      output alucontrol, illegal, mf_sel, hi, lo, busy, stall
   );
endinterface

// File: rtl/aludec_md_core.sv
// Iterative multiply/divide engine: shift-add multiply, restoring divide on
// operand magnitudes, one bit per cycle, sign correction in the FIX state.
module md_core
   import aludec_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_div,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res_hi,
   output logic [WIDTH-1:0] res_lo
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   md_state_e        state_r;
   logic [CNT_W-1:0] count_r;
   logic [WIDTH-1:0] m_r;
   logic [WIDTH-1:0] acc_hi_r;
   logic [WIDTH-1:0] acc_lo_r;
   logic             is_div_r;
   logic             neg_lo_r;
   logic             neg_hi_r;
   logic             divzero_r;

   logic             a_neg_s;
   logic             b_neg_s;
   logic [WIDTH-1:0] a_mag_s;
   logic [WIDTH-1:0] b_mag_s;
   logic [WIDTH:0]   mul_sum_s;
   logic [WIDTH:0]   div_shift_s;
   logic [WIDTH:0]   div_diff_s;
   logic             div_ok_s;
   logic             last_s;
   logic [2*WIDTH-1:0] prod_s;

   assign a_neg_s = is_signed & a[WIDTH-1];
   assign b_neg_s = is_signed & b[WIDTH-1];
   assign a_mag_s = a_neg_s ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
   assign b_mag_s = b_neg_s ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;

   // Multiplier bit in acc_lo_r[0] selects whether the multiplicand is added.
   assign mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
   // Partial remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits.
   assign div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
   assign div_diff_s  = div_shift_s - {1'b0, m_r};
   assign div_ok_s    = ~div_diff_s[WIDTH];
   assign last_s      = (count_r == CNT_W'(WIDTH - 1));
   assign prod_s      = {acc_hi_r, acc_lo_r};

   // Sequencer and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= MD_IDLE;
         count_r   <= {CNT_W{1'b0}};
         m_r       <= {WIDTH{1'b0}};
         acc_hi_r  <= {WIDTH{1'b0}};
         acc_lo_r  <= {WIDTH{1'b0}};
         is_div_r  <= 1'b0;
         neg_lo_r  <= 1'b0;
         neg_hi_r  <= 1'b0;
         divzero_r <= 1'b0;
      end else begin
         case (state_r)
            MD_IDLE: begin
               if (start) begin
                  m_r       <= is_div ? b_mag_s : a_mag_s;
                  acc_lo_r  <= is_div ? a_mag_s : b_mag_s;
                  acc_hi_r  <= {WIDTH{1'b0}};
                  is_div_r  <= is_div;
                  neg_lo_r  <= a_neg_s ^ b_neg_s;
                  neg_hi_r  <= is_div & a_neg_s;
                  divzero_r <= is_div & (b == {WIDTH{1'b0}});
                  count_r   <= {CNT_W{1'b0}};
                  state_r   <= is_div ? MD_DIV : MD_MUL;
               end
            end
            MD_MUL: begin
               {acc_hi_r, acc_lo_r} <= {mul_sum_s, acc_lo_r[WIDTH-1:1]};
               count_r              <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
               if (last_s) begin
                  state_r <= MD_FIX;
               end
            end
            MD_DIV: begin
               acc_hi_r <= div_ok_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
               acc_lo_r <= {acc_lo_r[WIDTH-2:0], div_ok_s};
               count_r  <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
               if (last_s) begin
                  state_r <= MD_FIX;
               end
            end
            MD_FIX: begin
               count_r <= {CNT_W{1'b0}};
               state_r <= MD_IDLE;
            end
            default: begin
               state_r <= MD_IDLE;
            end
         endcase
      end
   end

   assign busy = (state_r != MD_IDLE);
   assign done = (state_r == MD_FIX);

   // Sign correction; divide-by-zero keeps the all-ones quotient uncorrected.
   always_comb begin
      res_hi = acc_hi_r;
      res_lo = acc_lo_r;
      if (!is_div_r) begin
         if (neg_lo_r) begin
            {res_hi, res_lo} = -prod_s;
         end else begin
            {res_hi, res_lo} = prod_s;
         end
      end else begin
         res_lo = (neg_lo_r && !divzero_r) ? -acc_lo_r : acc_lo_r;
         res_hi = neg_hi_r ? -acc_hi_r : acc_hi_r;
      end
   end

endmodule

// File: rtl/aludec_md.sv
// Decode-stage ALU control decoder with HI/LO registers, hazard stall and an
// iterative multiply/divide engine.
module aludec_md
   import aludec_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
) (
   input  logic  clk,
   input  logic  rst_n,
   aludec_md_if.slave bus
);

   logic [CTRL_W-1:0] alucontrol_s;
   logic              illegal_s;
   logic [1:0]        mf_sel_s;
   logic              hilo_class_s;
   logic              stall_s;
   logic              accept_s;
   logic              start_s;
   logic              mthi_s;
   logic              mtlo_s;
   logic              busy_s;
   logic              done_s;
   logic [WIDTH-1:0]  res_hi_s;
   logic [WIDTH-1:0]  res_lo_s;
   logic [WIDTH-1:0]  hi_r;
   logic [WIDTH-1:0]  lo_r;

   // ALU control, illegal-funct flag and HI/LO read select.
   always_comb begin
      alucontrol_s = CTRL_W'(ALUCTRL_ADD);
      illegal_s    = 1'b0;
      mf_sel_s     = MF_NONE;
      case (bus.aluop)
         ALUOP_ADD: alucontrol_s = CTRL_W'(ALUCTRL_ADD);
         ALUOP_SUB: alucontrol_s = CTRL_W'(ALUCTRL_SUB);
         ALUOP_SLT: alucontrol_s = CTRL_W'(ALUCTRL_SLT);
         ALUOP_RTYPE: begin
            case (bus.funct)
               FUNCT_ADD, FUNCT_ADDU: alucontrol_s = CTRL_W'(ALUCTRL_ADD);
               FUNCT_SUB, FUNCT_SUBU: alucontrol_s = CTRL_W'(ALUCTRL_SUB);
               FUNCT_AND:  alucontrol_s = CTRL_W'(ALUCTRL_AND);
               FUNCT_OR:   alucontrol_s = CTRL_W'(ALUCTRL_OR);
               FUNCT_XOR:  alucontrol_s = CTRL_W'(ALUCTRL_XOR);
               FUNCT_NOR:  alucontrol_s = CTRL_W'(ALUCTRL_NOR);
               FUNCT_SLT:  alucontrol_s = CTRL_W'(ALUCTRL_SLT);
               FUNCT_SLTU: alucontrol_s = CTRL_W'(ALUCTRL_SLTU);
               FUNCT_MFHI: mf_sel_s     = MF_HI;
               FUNCT_MFLO: mf_sel_s     = MF_LO;
               default: begin
                  if (is_hilo_funct(bus.funct)) begin
                     illegal_s = 1'b0;
                  end else begin
                     illegal_s = 1'b1;
                  end
               end
            endcase
         end
         default: alucontrol_s = CTRL_W'(ALUCTRL_ADD);
      endcase
   end

   assign hilo_class_s = (bus.aluop == ALUOP_RTYPE) && is_hilo_funct(bus.funct);
   assign stall_s      = bus.issue & busy_s & hilo_class_s;
   assign accept_s     = bus.issue & ~stall_s & hilo_class_s;
   assign start_s      = accept_s & (bus.funct[5:2] == 4'b0110);
   assign mthi_s       = accept_s & (bus.funct == FUNCT_MTHI);
   assign mtlo_s       = accept_s & (bus.funct == FUNCT_MTLO);

   md_core #(.WIDTH(WIDTH)) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start_s),
      .is_div    (bus.funct[1]),
      .is_signed (~bus.funct[0]),
      .a         (bus.srca),
      .b         (bus.srcb),
      .busy      (busy_s),
      .done      (done_s),
      .res_hi    (res_hi_s),
      .res_lo    (res_lo_s)
   );

   // HI/LO: engine results on completion, otherwise MTHI/MTLO writes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_r <= {WIDTH{1'b0}};
         lo_r <= {WIDTH{1'b0}};
      end else if (done_s) begin
         hi_r <= res_hi_s;
         lo_r <= res_lo_s;
      end else begin
         if (mthi_s) begin
            hi_r <= bus.srca;
         end
         if (mtlo_s) begin
            lo_r <= bus.srca;
         end
      end
   end

   assign bus.alucontrol = alucontrol_s;
   assign bus.illegal    = illegal_s;
   assign bus.mf_sel     = mf_sel_s;
   assign bus.hi         = hi_r;
   assign bus.lo         = lo_r;
   assign bus.busy       = busy_s;
   assign bus.stall      = stall_s;

endmodule

// File: tb/tb_aludec_md.sv
// Bench for aludec_md: decode vector table, scoreboarded mult/div results,
// and hand-written hazard, FIX-overlap and mid-operation reset sequences.
module tb_aludec_md;
   import aludec_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic [63:0] exp_q[$];

   aludec_md_if #(.WIDTH(W), .CTRL_W(4)) bus ();

   aludec_md #(.WIDTH(W), .CTRL_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] aluop;
      logic [5:0] funct;
      logic [3:0] ctrl;
      logic       ill;
      logic [1:0] mf;
   } dec_vec_t;

   dec_vec_t vecs[20];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] p;
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic [31:0] q;
      logic [31:0] r;
      sa = a;
      sb = b;
      case (f)
         FUNCT_MULT: begin
            p = 64'(sa) * 64'(sb);
            return p;
         end
         FUNCT_MULTU: return {32'h0, a} * {32'h0, b};
         FUNCT_DIV: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {r, q};
         end
         FUNCT_DIVU: begin
            if (b == 32'h0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'h0;
      endcase
   endfunction

   task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic iss,
                        input logic [31:0] a, input logic [31:0] b);
      bus.aluop = op;
      bus.funct = f;
      bus.issue = iss;
      bus.srca  = a;
      bus.srcb  = b;
   endtask

   // After the accept edge: count busy cycles, then pop and compare HI/LO.
   task automatic finish_md(input string name);
      int n;
      logic [63:0] e;
      logic fell;
      n = 0;
      fell = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!bus.busy) begin
            fell = 1'b1;
            break;
         end
         n++;
      end
      chk({name, " busy_fell"}, 64'(fell), 64'(1));
      chk({name, " busy_cycles"}, 64'(n), 64'(W + 1));
      e = exp_q.pop_front();
      chk({name, " hi"}, 64'(bus.hi), 64'(e[63:32]));
      chk({name, " lo"}, 64'(bus.lo), 64'(e[31:0]));
   endtask

   task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp);
      exp_q.push_back(exp);
      @(negedge clk);
      drive(ALUOP_RTYPE, f, 1'b1, a, b);
      #1 chk({name, " stall"}, 64'(bus.stall), 64'(0));
      @(posedge clk);
      #1 bus.issue = 1'b0;
      finish_md(name);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [5:0]  rf;
      int n_st;

      vecs[0]  = '{ALUOP_ADD,   6'b000000, 4'b0010, 1'b0, 2'b00};
      vecs[1]  = '{ALUOP_SUB,   6'b100100, 4'b0110, 1'b0, 2'b00};
      vecs[2]  = '{ALUOP_SLT,   6'b111111, 4'b0111, 1'b0, 2'b00};
      vecs[3]  = '{ALUOP_RTYPE, 6'b100000, 4'b0010, 1'b0, 2'b00};
      vecs[4]  = '{ALUOP_RTYPE, 6'b100001, 4'b0010, 1'b0, 2'b00};
      vecs[5]  = '{ALUOP_RTYPE, 6'b100010, 4'b0110, 1'b0, 2'b00};
      vecs[6]  = '{ALUOP_RTYPE, 6'b100011, 4'b0110, 1'b0, 2'b00};
      vecs[7]  = '{ALUOP_RTYPE, 6'b100100, 4'b0000, 1'b0, 2'b00};
      vecs[8]  = '{ALUOP_RTYPE, 6'b100101, 4'b0001, 1'b0, 2'b00};
      vecs[9]  = '{ALUOP_RTYPE, 6'b100110, 4'b0011, 1'b0, 2'b00};
      vecs[10] = '{ALUOP_RTYPE, 6'b100111, 4'b0100, 1'b0, 2'b00};
      vecs[11] = '{ALUOP_RTYPE, 6'b101010, 4'b0111, 1'b0, 2'b00};
      vecs[12] = '{ALUOP_RTYPE, 6'b101011, 4'b1111, 1'b0, 2'b00};
      vecs[13] = '{ALUOP_RTYPE, 6'b010000, 4'b0010, 1'b0, 2'b01};
      vecs[14] = '{ALUOP_RTYPE, 6'b010010, 4'b0010, 1'b0, 2'b10};
      vecs[15] = '{ALUOP_RTYPE, 6'b011011, 4'b0010, 1'b0, 2'b00};
      vecs[16] = '{ALUOP_RTYPE, 6'b010011, 4'b0010, 1'b0, 2'b00};
      vecs[17] = '{ALUOP_RTYPE, 6'b111111, 4'b0010, 1'b1, 2'b00};
      vecs[18] = '{ALUOP_RTYPE, 6'b000000, 4'b0010, 1'b1, 2'b00};
      vecs[19] = '{ALUOP_ADD,   6'b010000, 4'b0010, 1'b0, 2'b00};

      drive(2'b00, 6'b000000, 1'b0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      chk("reset busy", 64'(bus.busy), 64'(0));
      chk("reset hi", 64'(bus.hi), 64'(0));
      chk("reset lo", 64'(bus.lo), 64'(0));
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive(vecs[i].aluop, vecs[i].funct, 1'b0, 32'h0, 32'h0);
         #1 chk($sformatf("decode[%0d] ctrl/ill/mf", i),
                64'({bus.alucontrol, bus.illegal, bus.mf_sel}),
                64'({vecs[i].ctrl, vecs[i].ill, vecs[i].mf}));
      end

      run_md("mult", FUNCT_MULT,  32'hFFFF_FFFD, 32'h0000_0007, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
      run_md("multu", FUNCT_MULTU, 32'hFFFF_FFFD, 32'h0000_0007, {32'h0000_0006, 32'hFFFF_FFEB});
      run_md("div", FUNCT_DIV,   32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_md("divu0", FUNCT_DIVU,  32'h0000_0064, 32'h0000_0000, {32'h0000_0064, 32'hFFFF_FFFF});
      run_md("div0s", FUNCT_DIV,   32'hFFFF_FFFB, 32'h0000_0000, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
      run_md("divmin", FUNCT_DIV,  32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});

      for (int i = 0; i < 8; i++) begin
         rf = 6'b011000 | 6'(i % 4);
         ra = $urandom;
         rb = (i >= 4) ? 32'($urandom_range(1, 15)) : $urandom;
         if (rb[3:0] == 4'h5) rb = -rb;
         run_md($sformatf("rand%0d", i), rf, ra, rb, model(rf, ra, rb));
      end

      // Non-R-type issue with an MD funct neither starts the engine nor stalls.
      @(negedge clk);
      drive(ALUOP_ADD, FUNCT_MULT, 1'b1, 32'h5, 32'h6);
      #1 chk("nonr stall", 64'(bus.stall), 64'(0));
      @(negedge clk);
      chk("nonr busy", 64'(bus.busy), 64'(0));
      bus.issue = 1'b0;

      // Hazard: ADDs during MULT never stall, MFHI stalls until the product lands.
      exp_q.push_back(model(FUNCT_MULT, 32'h0001_2345, 32'hFFFF_0003));
      @(negedge clk);
      drive(ALUOP_RTYPE, FUNCT_MULT, 1'b1, 32'h0001_2345, 32'hFFFF_0003);
      @(posedge clk);
      #1 bus.issue = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         drive(ALUOP_ADD, FUNCT_ADD, 1'b1, 32'h0, 32'h0);
         #1 chk($sformatf("add_busy%0d stall", i), 64'(bus.stall), 64'(0));
      end
      @(negedge clk);
      drive(ALUOP_RTYPE, FUNCT_MFHI, 1'b1, 32'h0, 32'h0);
      n_st = 0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (!bus.busy) break;
         if (bus.stall) n_st++;
         @(negedge clk);
      end
      chk("mfhi stall_cycles", 64'(n_st), 64'(W + 1 - 4));
      chk("mfhi stall_released", 64'(bus.stall), 64'(0));
      chk("mfhi mf_sel", 64'(bus.mf_sel), 64'(MF_HI));
      begin
         logic [63:0] e;
         e = exp_q.pop_front();
         chk("mfhi hi", 64'(bus.hi), 64'(e[63:32]));
      end
      @(posedge clk);
      #1 bus.issue = 1'b0;

      // DIV issued during FIX of a MULT stalls, then starts on the first idle cycle.
      exp_q.push_back(model(FUNCT_MULTU, 32'h0000_1000, 32'h0010_0001));
      @(negedge clk);
      drive(ALUOP_RTYPE, FUNCT_MULTU, 1'b1, 32'h0000_1000, 32'h0010_0001);
      @(posedge clk);
      #1 bus.issue = 1'b0;
      repeat (W) @(negedge clk);
      @(negedge clk);
      drive(ALUOP_RTYPE, FUNCT_DIV, 1'b1, 32'hFFFF_FF9C, 32'h0000_0007);
      #1 chk("fix busy", 64'(bus.busy), 64'(1));
      chk("fix stall", 64'(bus.stall), 64'(1));
      @(negedge clk);
      #1 chk("post_fix stall", 64'(bus.stall), 64'(0));
      begin
         logic [63:0] e;
         e = exp_q.pop_front();
         chk("post_fix hi", 64'(bus.hi), 64'(e[63:32]));
         chk("post_fix lo", 64'(bus.lo), 64'(e[31:0]));
      end
      exp_q.push_back({32'hFFFF_FFFE, 32'hFFFF_FFF2});
      @(posedge clk);
      #1 bus.issue = 1'b0;
      finish_md("div_after_fix");

      // MTHI/MTLO write at the next edge without going busy.
      @(negedge clk);
      drive(ALUOP_RTYPE, FUNCT_MTHI, 1'b1, 32'h1234_5678, 32'h0);
      @(negedge clk);
      drive(ALUOP_RTYPE, FUNCT_MTLO, 1'b1, 32'hCAFE_BABE, 32'h0);
      chk("mthi hi", 64'(bus.hi), 64'(32'h1234_5678));
      chk("mthi busy", 64'(bus.busy), 64'(0));
      @(negedge clk);
      bus.issue = 1'b0;
      chk("mtlo lo", 64'(bus.lo), 64'(32'hCAFE_BABE));

      // Reset in the middle of a DIV clears everything at once.
      drive(ALUOP_RTYPE, FUNCT_DIV, 1'b1, 32'h0000_0064, 32'h0000_0007);
      @(posedge clk);
      #1 bus.issue = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk("rst busy", 64'(bus.busy), 64'(0));
      chk("rst hi", 64'(bus.hi), 64'(0));
      chk("rst lo", 64'(bus.lo), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      run_md("mult_after_rst", FUNCT_MULT, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
